// File: rtl/stoch_decode_mat.sv
// rtl/stoch_decode_mat.sv - windowed 1s counter decoding a matrix of stochastic bitstreams
module stoch_decode_mat #(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int WINDOW_BITS = 8
) (
    input  logic                                              CLK,
    input  logic                                              nRST,
    input  logic                                              start,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                 A,
    output logic                                              busy,
    output logic                                              done,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_BITS:0]  Y
);
    localparam int CW = WINDOW_BITS + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0] acc;
    logic [WINDOW_BITS-1:0]                    cnt;
    logic                                      last;

    assign last = (cnt == {WINDOW_BITS{1'b1}});

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Y is loaded with the final sample folded in, so the last RUN cycle counts.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc <= '0;
            cnt <= '0;
            Y   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + WINDOW_BITS'(1);
                    for (int i = 0; i < NUM_ROWS; i++) begin
                        for (int j = 0; j < NUM_COLS; j++) begin
                            acc[i][j] <= acc[i][j] + {{WINDOW_BITS{1'b0}}, A[i][j]};
                            if (last) begin
                                Y[i][j] <= acc[i][j] + {{WINDOW_BITS{1'b0}}, A[i][j]};
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stoch_decode_mat.sv
// tb/tb_stoch_decode_mat.sv - directed and random window checks for stoch_decode_mat
module tb_stoch_decode_mat;
    localparam int WB = 4;
    localparam int N  = 1 << WB;

    logic                      CLK = 1'b0;
    logic                      nRST;
    logic                      start;
    logic [1:0][1:0]           A;
    logic                      busy;
    logic                      done;
    logic [1:0][1:0][WB:0]     Y;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_y [2][2];

    stoch_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_BITS(WB)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .A(A),
        .busy(busy), .done(done), .Y(Y)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_y(input string tag, input int exp [2][2]);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                chk($sformatf("%s_y%0d%0d", tag, i, j), int'(Y[i][j]), exp[i][j]);
    endtask

    // Stimulus per sample index k (0..N-1) of a window.
    function automatic logic stim(input int mode, input int k, input int i, input int j);
        case (mode)
            1: return 1'b1;
            2: return 1'b0;
            3, 4: begin
                if (i == 0 && j == 0) return 1'b0;
                if (i == 0 && j == 1) return (k % 2 == 0);
                if (i == 1 && j == 0) return (k % 4 == 0);
                return (mode == 3) ? 1'b1 : (k != N - 1);
            end
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Caller must be at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_window(input int mode, input bit poke, output int done_cyc);
        int exp [2][2];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                exp[i][j] = 0;
        start = 1'b1;
        A     = '0;
        @(negedge CLK);
        chk("busy_first", int'(busy), 1);
        chk("done_first", int'(done), 0);
        chk_y("hold_at_start", last_y);
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    A[i][j] = stim(mode, k, i, j);
                    exp[i][j] += int'(A[i][j]);
                end
            start = (poke && (k == 4 || k == 9));
            @(negedge CLK);
            if (k < N - 1) begin
                chk($sformatf("busy_run%0d", k), int'(busy), 1);
                chk($sformatf("done_run%0d", k), int'(done), 0);
            end
        end
        start = 1'b0;
        chk("done_pulse", int'(done), 1);
        chk("busy_in_done", int'(busy), 0);
        chk_y("result", exp);
        done_cyc = cyc;
        last_y   = exp;
        if (poke) start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("done_after", int'(done), 0);
        chk("busy_after", int'(busy), 0);
        chk_y("hold_after", last_y);
        if (poke) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge CLK);
                chk($sformatf("no_restart%0d", c), int'(busy), 0);
                chk($sformatf("no_done%0d", c), int'(done), 0);
            end
            chk_y("hold_idle", last_y);
        end
    endtask

    initial begin
        int d1;
        int d2;
        int done_seen;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                last_y[i][j] = 0;
        nRST  = 1'b0;
        start = 1'b0;
        A     = '0;
        repeat (3) @(negedge CLK);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk_y("reset", last_y);
        nRST = 1'b1;
        @(negedge CLK);

        run_window(1, 1'b0, d1);
        run_window(3, 1'b0, d1);
        run_window(4, 1'b0, d1);
        run_window(1, 1'b1, d1);
        for (int r = 0; r < 3; r++) run_window(0, 1'b0, d1);

        run_window(1, 1'b0, d1);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        A     = '1;
        repeat (7) @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                last_y[i][j] = 0;
        chk_y("async_reset", last_y);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_done", int'(done), 0);
        @(negedge CLK);
        nRST = 1'b1;
        done_seen = 0;
        for (int c = 0; c < N + 4; c++) begin
            @(negedge CLK);
            if (done) done_seen++;
        end
        chk("aborted_no_done", done_seen, 0);
        chk("aborted_idle", int'(busy), 0);
        run_window(2, 1'b0, d1);

        run_window(1, 1'b0, d1);
        run_window(2, 1'b0, d2);
        chk("back_to_back_gap", d2 - d1, N + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
